// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared types and key map for the keypad scanner
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_kind_e;

  // Indexed by {col[1:0], row[1:0]}; row0 is the top row.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

endpackage

// File: rtl/keypad_frame_scan.sv
// rtl/keypad_frame_scan.sv - row synchronizer, column strobe rotation and per-frame key classification
module keypad_frame_scan
  import keypad_scanner_pkg::*;
#(
  parameter int N_SETTLE = 1000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  output logic        frame_valid_o,
  output frame_kind_e frame_kind_o,
  output logic [3:0]  frame_code_o
);
  localparam int CW = (N_SETTLE > 1) ? $clog2(N_SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(N_SETTLE - 1);

  logic [CW-1:0] settle_q, settle_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    code_q, code_d;

  logic          capture;
  logic [3:0]    low;
  logic [1:0]    col_hits;
  logic [1:0]    row_idx;
  logic [1:0]    hits_base;
  logic [2:0]    hits_sum;

  always_comb begin
    capture   = (settle_q == SETTLE_LAST);
    low       = ~row_s2_q;
    col_hits  = 2'd2;
    row_idx   = 2'd0;
    case (low)
      4'b0000: col_hits = 2'd0;
      4'b0001: begin col_hits = 2'd1; row_idx = 2'd0; end
      4'b0010: begin col_hits = 2'd1; row_idx = 2'd1; end
      4'b0100: begin col_hits = 2'd1; row_idx = 2'd2; end
      4'b1000: begin col_hits = 2'd1; row_idx = 2'd3; end
      default: col_hits = 2'd2;
    endcase
    // Hit count saturates at 2: anything beyond "one key" is just MULTI.
    hits_base = (col_idx_q == 2'd0) ? 2'd0 : hits_q;
    hits_sum  = {1'b0, hits_base} + {1'b0, col_hits};
    hits_d    = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    code_d    = (col_hits == 2'd1) ? KEY_MAP[{col_idx_q, row_idx}] : code_q;

    settle_d  = capture ? '0 : settle_q + 1'b1;
    col_idx_d = capture ? col_idx_q + 2'd1 : col_idx_q;
    col_d     = capture ? {col_q[2:0], col_q[3]} : col_q;

    frame_valid_o = capture && (col_idx_q == 2'd3);
    frame_code_o  = code_d;
    case (hits_d)
      2'd0:    frame_kind_o = FR_NONE;
      2'd1:    frame_kind_o = FR_SINGLE;
      default: frame_kind_o = FR_MULTI;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_q  <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      hits_q    <= 2'd0;
      code_q    <= 4'h0;
    end else begin
      settle_q  <= settle_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      row_s1_q  <= row_i;
      row_s2_q  <= row_s1_q;
      if (capture) begin
        hits_q <= hits_d;
        code_q <= code_d;
      end
    end
  end

  assign col_o = col_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner: frame debounce FSM and valid/ack key handshake
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int N_SETTLE = 1000,
  parameter int N_STABLE = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  input  logic       ack_i,
  output logic [3:0] col_o,
  output logic [3:0] key_o,
  output logic       key_down_o,
  output logic       key_pulse_o,
  output logic       key_avail_o,
  output logic       overrun_o
);
  localparam int SW = $clog2(N_STABLE + 1);
  localparam logic [SW-1:0] STABLE_N = SW'(N_STABLE);

  logic        frame_valid;
  frame_kind_e frame_kind;
  logic [3:0]  frame_code;

  kp_state_e   state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  cand_q, cand_d, key_q, key_d;
  logic        down_q, down_d, avail_q, avail_d, overrun_q, overrun_d;
  logic        accept, accept_q, pulse_q, single, same_key;

  keypad_frame_scan #(.N_SETTLE(N_SETTLE)) u_scan (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .row_i         (row_i),
    .col_o         (col_o),
    .frame_valid_o (frame_valid),
    .frame_kind_o  (frame_kind),
    .frame_code_o  (frame_code)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    key_d    = key_q;
    down_d   = down_q;
    accept   = 1'b0;
    cnt_inc  = cnt_q + 1'b1;
    single   = (frame_kind == FR_SINGLE);
    same_key = single && (frame_code == key_q);
    if (frame_valid) begin
      case (state_q)
        ST_IDLE: if (single) begin
          cand_d = frame_code;
          cnt_d  = 1;
          if (N_STABLE == 1) accept = 1'b1;
          else               state_d = ST_PRESS_DB;
        end
        ST_PRESS_DB: begin
          if (!single) begin
            state_d = ST_IDLE;
          end else if (frame_code != cand_q) begin
            cand_d = frame_code;
            cnt_d  = 1;
          end else if (cnt_inc == STABLE_N) begin
            accept = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_HELD: if (!same_key) begin
          cnt_d = 1;
          if (N_STABLE == 1) begin
            down_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RELEASE_DB;
          end
        end
        default: begin
          if (same_key) begin
            state_d = ST_HELD;
          end else if (cnt_inc == STABLE_N) begin
            down_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
    if (accept) begin
      key_d   = frame_code;
      down_d  = 1'b1;
      state_d = ST_HELD;
    end
    // A same-cycle ack consumes the old key, so the new one is not an overrun.
    if (accept) begin
      avail_d   = 1'b1;
      overrun_d = avail_q && !ack_i;
    end else if (ack_i && avail_q) begin
      avail_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      avail_d   = avail_q;
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cand_q    <= 4'h0;
      key_q     <= 4'h0;
      down_q    <= 1'b0;
      avail_q   <= 1'b0;
      overrun_q <= 1'b0;
      accept_q  <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      key_q     <= key_d;
      down_q    <= down_d;
      avail_q   <= avail_d;
      overrun_q <= overrun_d;
      accept_q  <= accept;
      pulse_q   <= accept_q;
    end
  end

  assign key_o       = key_q;
  assign key_down_o  = down_q;
  assign key_pulse_o = pulse_q;
  assign key_avail_o = avail_q;
  assign overrun_o   = overrun_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad (Pmod KYPD style) so players can enter quiz answers as hex digits; it is the input-side counterpart of the 8-digit SSD scan driver.
- Strobes one column low at a time, samples the active-low rows, debounces across whole scan frames, and reports one hex key code.
- Each accepted press is delivered through a latched valid/ack handshake to the game FSM, which runs on the same system clock.

Parameters:
- N_SETTLE, 1000, clock cycles each column is driven before rows are sampled; must be >= 4.
- N_STABLE, 4, consecutive identical frames required to accept a press or a release; must be >= 1.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous reset, active-low: Reset=0 resets, release is synchronous to Clk.
- Row  in  4  keypad rows, active-low, pulled up; row0 is the top row.
- Ack  in  1  consumer acknowledge; clears Key_Avail.
- Col  out  4  column strobes, active-low, exactly one low at a time.
- Key  out  4  last accepted key code.
- Key_Down  out  1  debounced level, high while the accepted key is held.
- Key_Pulse  out  1  single-cycle strobe when a press is accepted.
- Key_Avail  out  1  high from acceptance until Ack.
- Overrun  out  1  a new press was accepted while Key_Avail was already high.

Behaviour:
- Reset values: Col=4'b1110 (column 0), Key=0, Key_Down=0, Key_Pulse=0, Key_Avail=0, Overrun=0, all counters 0, FSM in IDLE.
- Row input: passes through a 2-flop synchronizer before use.
- Column scan: a settle counter runs 0..N_SETTLE-1 per column.
  - At count N_SETTLE-1 the synced Row is captured for that column, then Col rotates 1110->1101->1011->0111->1110.
  - Frame = 4*N_SETTLE cycles. The frame is evaluated on the cycle column 3 is captured.
- Frame result is one of NONE (no row low), SINGLE(code) (exactly one low bit in the frame), or MULTI (two or more).
- Key map, rows top to bottom:
  - col0 = 1,4,7,0
  - col1 = 2,5,8,F
  - col2 = 3,6,9,E
  - col3 = A,B,C,D
- FSM states IDLE, PRESS_DB, HELD, RELEASE_DB, with stable counter cnt:
  - IDLE: on SINGLE(k), cand=k, cnt=1. If N_STABLE==1, go straight to accept; otherwise go to PRESS_DB.
  - PRESS_DB:
    - SINGLE(cand): cnt++. When cnt reaches N_STABLE -> accept.
    - SINGLE(other): cand=other, cnt=1.
    - NONE or MULTI: back to IDLE.
  - Accept: Key=cand and Key_Down=1 in the same cycle; Key_Pulse=1 for the next cycle only; Key_Avail=1; go to HELD.
  - HELD: any frame other than SINGLE(Key) -> RELEASE_DB with cnt=1.
  - RELEASE_DB:
    - SINGLE(Key): return to HELD.
    - Otherwise cnt++. At N_STABLE: Key_Down=0, go to IDLE. Key keeps its value.
  - A different key pressed while one is held needs a full release and then its own press debounce.
- Handshake:
  - Ack with Key_Avail high clears Key_Avail and Overrun the next cycle.
  - Ack while Key_Avail is low has no effect.
  - Accept while Key_Avail is already high: Key updates, Overrun=1, Key_Avail stays 1.
  - Accept and Ack in the same cycle: the accept wins. Key_Avail stays 1; Overrun is not set.
- Latency: Key_Pulse follows the last qualifying frame evaluation by 2 cycles (accept cycle + pulse cycle).
- Reset asserted mid-frame: everything returns to the reset values immediately and the scan restarts at column 0.

Decomposition:
- Shared package holds:
  - FSM state encodings (IDLE, PRESS_DB, HELD, RELEASE_DB).
  - Frame-result encoding (NONE, SINGLE, MULTI).
  - The 16-entry column/row-to-hex key map constant.
- Sub-module keypad_frame_scan: synchronizer, settle counter, column rotation and frame accumulation. Outputs frame_valid, frame_kind and frame_code.
- keypad_scanner itself holds the debounce FSM and the handshake.

Test Plan:
Bench parameters: N_SETTLE=4, N_STABLE=2, frame = 16 cycles.
- Idle scan: Row=4'b1111 -> Col cycles 1110,1101,1011,0111 with 4 cycles each; all outputs stay 0.
- Press '5' (row1 low while col1 driven) for 3 frames -> Key=4'h5, Key_Pulse high exactly 1 cycle, 2 cycles after the 2nd frame evaluation; Key_Down=1 and Key_Avail=1.
- Bounce: press '5' for 1 frame, release 1 frame, press 2 frames -> exactly one Key_Pulse, Key=5.
- Hold '5', release 2 frames, press 'D' (row3 low, col3) 2 frames with no Ack -> Key=4'hD, Overrun=1, Key_Avail=1. Then pulse Ack -> Key_Avail=0 and Overrun=0 the next cycle.
- Hold 1 and 2 together (row0 low on col0 and col1) for 4 frames -> no Key_Pulse; Key_Down stays 0.
- Drive Reset=0 mid-column-2 while '9' is HELD -> Col=1110 and all outputs 0 immediately; after release the scan restarts from column 0.
